fetch_queue: RTL

Instruction-fetch stage that sits directly upstream of the IF/DE pipeline register and decouples the pipeline from a variable-latency instruction memory port. It generates sequential word-address fetch requests and buffers returned instructions with their PC+4 in a small FIFO. It presents one instruction per cycle to decode under a valid/ready handshake, where ready is the pipeline's ~Stall. On a taken branch (redirect) it flushes its contents and restarts fetching at the target.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_queue_fifo.sv | 86 ++++++++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_queue_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int INST_W      = 32;

    // Default word address fetched first after reset (byte address 0x00400000).
    localparam logic [WORD_ADDR_W-1:0] FQ_RESET_PC = 30'h100000;

    // One buffered fetch: the instruction and the word address that follows it.
    typedef struct packed {
        logic [INST_W-1:0]      inst;
        logic [WORD_ADDR_W-1:0] pc_plus4;
    } fq_entry_t;

    // Request tracking: nothing owed, a response owed and kept, or owed and discarded.
    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_WAIT = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_e;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched entries with push/pop/clear and a registered head.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fq_entry_t              push_data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output logic                   head_valid_o,
    output fq_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fq_entry_t        head_q;
    logic             head_valid_q;

    // Next storage, pointer and occupancy; clear overrides any push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_i && !pop_i) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_i && pop_i) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Storage and pointer registers; the head is registered from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= mem_d[rd_ptr_d];
            head_valid_q <= (count_d != '0);
        end
    end

    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: one outstanding memory request, credit-limited
// buffering of returned instructions, and flush/restart on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                      DEPTH    = 4,
    parameter logic [WORD_ADDR_W-1:0]  RESET_PC = FQ_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req_valid,
    output logic [WORD_ADDR_W-1:0] mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [INST_W-1:0]      mem_resp_inst,
    output logic                   out_valid,
    output logic [INST_W-1:0]      out_inst,
    output logic [WORD_ADDR_W-1:0] out_pc_plus4,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [WORD_ADDR_W-1:0] redirect_target
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fq_state_e              state_q, state_d;
    logic [WORD_ADDR_W-1:0] fetch_pc_q;
    logic [WORD_ADDR_W-1:0] req_pc_plus4_q;
    logic [CNT_W-1:0]       count_s;
    logic                   outstanding_s;
    logic                   credit_ok_s;
    logic                   req_fire_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   head_valid_s;
    fq_entry_t              head_s;
    fq_entry_t              push_data_s;

    // Every accepted request must have a free slot waiting for its response.
    assign outstanding_s = (state_q != FQ_IDLE);
    assign credit_ok_s   = ({1'b0, count_s} + {{CNT_W{1'b0}}, outstanding_s})
                           < (CNT_W + 1)'(DEPTH);
    assign push_data_s   = '{inst: mem_resp_inst, pc_plus4: req_pc_plus4_q};

    // Request-tracking state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a redirect turns any response still owed into one to discard.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FQ_IDLE: begin
                if (req_fire_s) begin
                    state_d = redirect ? FQ_DROP : FQ_WAIT;
                end else begin
                    state_d = FQ_IDLE;
                end
            end
            FQ_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = FQ_IDLE;
                end else if (redirect) begin
                    state_d = FQ_DROP;
                end else begin
                    state_d = FQ_WAIT;
                end
            end
            FQ_DROP: begin
                if (mem_resp_valid) begin
                    state_d = FQ_IDLE;
                end else begin
                    state_d = FQ_DROP;
                end
            end
            default: state_d = FQ_IDLE;
        endcase
    end

    // Request, enqueue and dequeue strobes; redirect blocks both queue moves.
    always_comb begin
        mem_req_valid = 1'b0;
        if (reset) begin
            mem_req_valid = 1'b0;
        end else if ((state_q == FQ_IDLE) && credit_ok_s) begin
            mem_req_valid = 1'b1;
        end else begin
            mem_req_valid = 1'b0;
        end
        req_fire_s = mem_req_valid & mem_req_ready;
        push_s     = (state_q == FQ_WAIT) & mem_resp_valid & ~redirect;
        pop_s      = head_valid_s & out_ready & ~redirect;
    end

    // Fetch PC and the PC+1 carried with the in-flight request; target wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC;
            req_pc_plus4_q <= '0;
        end else begin
            if (redirect) begin
                fetch_pc_q <= redirect_target;
            end else if (req_fire_s) begin
                fetch_pc_q <= fetch_pc_q + 30'd1;
            end else begin
                fetch_pc_q <= fetch_pc_q;
            end
            if (req_fire_s) begin
                req_pc_plus4_q <= fetch_pc_q + 30'd1;
            end else begin
                req_pc_plus4_q <= req_pc_plus4_q;
            end
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_data_i  (push_data_s),
        .pop_i        (pop_s),
        .clear_i      (redirect),
        .head_valid_o (head_valid_s),
        .head_o       (head_s),
        .count_o      (count_s)
    );

    assign mem_req_addr = fetch_pc_q;
    assign out_valid    = head_valid_s;
    assign out_inst     = head_s.inst;
    assign out_pc_plus4 = head_s.pc_plus4;

endmodule
